// File: rtl/layer_sequencer.sv
// Control sequencer for a fully-connected network: drives one shared MAC and
// activation unit neuron by neuron and writes results into ping-pong hidden banks.
module layer_sequencer #(
    parameter  int N_IN        = 8,
    parameter  int N_NEU       = 4,
    parameter  int N_LAYER     = 3,
    parameter  int MAC_LAT     = 1,
    parameter  int ACT_TIMEOUT = 64,
    localparam int LW  = (N_LAYER > 1) ? $clog2(N_LAYER) : 1,
    localparam int NW  = (N_NEU > 1) ? $clog2(N_NEU) : 1,
    localparam int IMX = (N_IN > N_NEU) ? N_IN : N_NEU,
    localparam int IW  = (IMX > 1) ? $clog2(IMX) : 1,
    localparam int WN  = N_IN*N_NEU + (N_LAYER-1)*N_NEU*N_NEU,
    localparam int WAW = (WN > 1) ? $clog2(WN) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           act_ready,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [LW-1:0]  layer,
    output logic [NW-1:0]  neuron,
    output logic [IW-1:0]  in_idx,
    output logic           in_sel,
    output logic           rd_bank,
    output logic [WAW-1:0] w_addr,
    output logic           mac_clr,
    output logic           mac_en,
    output logic           mac_last,
    output logic           act_start,
    output logic           wr_en,
    output logic           wr_bank,
    output logic [NW-1:0]  wr_addr,
    output logic [15:0]    sample_cnt
);
    localparam int CMX = (MAC_LAT > ACT_TIMEOUT) ? MAC_LAT : ACT_TIMEOUT;
    localparam int CW  = $clog2(CMX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_MAC, S_DRAIN, S_ACT, S_WAIT, S_WRITE, S_DONE
    } state_t;

    state_t         r_state;
    logic [LW-1:0]  r_layer;
    logic [NW-1:0]  r_neuron;
    logic [IW-1:0]  r_in_idx;
    logic [WAW-1:0] r_w_addr;
    logic [CW-1:0]  r_cnt;
    logic           r_err;
    logic [15:0]    r_sample_cnt;

    logic [IW-1:0]  w_fan_m1;
    logic           w_last_term;

    assign w_fan_m1    = (r_layer == '0) ? IW'(N_IN-1) : IW'(N_NEU-1);
    assign w_last_term = (r_in_idx == w_fan_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_layer      <= '0;
            r_neuron     <= '0;
            r_in_idx     <= '0;
            r_w_addr     <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_sample_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_state  <= S_CLEAR;
                    r_layer  <= '0;
                    r_neuron <= '0;
                    r_w_addr <= '0;
                    r_err    <= 1'b0;
                end
                S_CLEAR: begin
                    r_in_idx <= '0;
                    r_state  <= S_MAC;
                end
                S_MAC: begin
                    // weight pointer runs across neurons and layers without rewinding
                    r_w_addr <= r_w_addr + 1'b1;
                    if (w_last_term) begin
                        r_cnt   <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_in_idx <= r_in_idx + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == CW'(MAC_LAT-1)) begin
                        r_cnt   <= '0;
                        r_state <= S_ACT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ACT: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (act_ready) begin
                        r_state <= S_WRITE;
                    end else if (r_cnt == CW'(ACT_TIMEOUT-1)) begin
                        r_state  <= S_IDLE;
                        r_err    <= 1'b1;
                        r_layer  <= '0;
                        r_neuron <= '0;
                        r_in_idx <= '0;
                        r_w_addr <= '0;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (r_neuron != NW'(N_NEU-1)) begin
                        r_neuron <= r_neuron + 1'b1;
                        r_state  <= S_CLEAR;
                    end else if (r_layer != LW'(N_LAYER-1)) begin
                        r_layer  <= r_layer + 1'b1;
                        r_neuron <= '0;
                        r_state  <= S_CLEAR;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_sample_cnt <= r_sample_cnt + 1'b1;
                    r_state      <= S_IDLE;
                    r_layer      <= '0;
                    r_neuron     <= '0;
                    r_in_idx     <= '0;
                    r_w_addr     <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Layer L reads the bank layer L-1 wrote; layer 0 reads the external input.
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign err        = r_err;
    assign layer      = r_layer;
    assign neuron     = r_neuron;
    assign in_idx     = r_in_idx;
    assign in_sel     = (r_layer != '0);
    assign rd_bank    = (r_layer != '0) & ~r_layer[0];
    assign w_addr     = r_w_addr;
    assign mac_clr    = (r_state == S_CLEAR);
    assign mac_en     = (r_state == S_MAC);
    assign mac_last   = (r_state == S_MAC) & w_last_term;
    assign act_start  = (r_state == S_ACT);
    assign wr_en      = (r_state == S_WRITE);
    assign wr_bank    = r_layer[0];
    assign wr_addr    = r_neuron;
    assign sample_cnt = r_sample_cnt;
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Synchronous scheduler that time-multiplexes one shared MAC unit and one activation unit across every neuron of a fully-connected network of N_LAYER layers.
- For each neuron it clears the accumulator, streams inputs and weights, waits for the activation result and writes it to a ping-pong hidden buffer.
- Sits between the top-level host start/done interface and the MAC, activation unit and buffer datapath.

Parameters:
- N_IN, 8, fan-in of layer 0 (external input vector length).
- N_NEU, 4, neurons per layer. Also the fan-in of every layer ≥1.
- N_LAYER, 3, number of layers.
- MAC_LAT, 1, MAC pipeline latency in cycles (≥1).
- ACT_TIMEOUT, 64, maximum number of WAIT_ACT cycles before error.
- Derived widths:
  - LW = max(1, clog2(N_LAYER))
  - NW = max(1, clog2(N_NEU))
  - IW = max(1, clog2(max(N_IN, N_NEU)))
  - WAW = max(1, clog2(N_IN*N_NEU + (N_LAYER-1)*N_NEU*N_NEU))

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin one inference. Sampled only in IDLE.
- act_ready  in  1  activation result valid. Sampled only in WAIT_ACT.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of an inference.
- err  out  1  sticky activation-timeout flag.
- layer  out  LW  current layer index.
- neuron  out  NW  current neuron index.
- in_idx  out  IW  input element index driven to the input buffers.
- in_sel  out  1  0 = external input, 1 = hidden buffer (in_sel = layer!=0).
- rd_bank  out  1  hidden bank read, equal to (layer-1)%2. Don't-care in layer 0.
- w_addr  out  WAW  weight memory address.
- mac_clr  out  1  clear accumulator.
- mac_en  out  1  accumulate the current input×weight.
- mac_last  out  1  marks the final term of the dot product.
- act_start  out  1  one-cycle activation launch.
- wr_en  out  1  hidden buffer write strobe.
- wr_bank  out  1  bank written, equal to layer%2.
- wr_addr  out  NW  write address, equal to neuron.
- sample_cnt  out  16  completed inferences, wraps at 2^16.

Behaviour:
- Reset: state=IDLE. All outputs and counters are 0, including err and sample_cnt.
- All control outputs are Moore outputs, decoded from registered state and counters.
- fan = N_IN when layer==0, otherwise fan = N_NEU.
- State machine:
  - IDLE: start=1 → CLEAR, with layer=0, neuron=0, w_addr=0, err cleared. start while busy is ignored.
  - CLEAR: mac_clr=1 for 1 cycle, in_idx=0 → MAC.
  - MAC: fan cycles with mac_en=1.
    - in_idx counts 0..fan-1.
    - w_addr increments by 1 after every mac_en cycle and is never re-zeroed mid-inference (running pointer).
    - mac_last=1 when in_idx==fan-1. Then → DRAIN.
  - DRAIN: MAC_LAT cycles, all strobes low → ACT.
  - ACT: act_start=1 for 1 cycle → WAIT_ACT.
  - WAIT_ACT: act_ready=1 → WRITE. After ACT_TIMEOUT cycles without act_ready → IDLE with err=1 and no done pulse. act_ready outside WAIT_ACT is ignored.
  - WRITE: wr_en=1 for 1 cycle. Then:
    - neuron<N_NEU-1: neuron++ → CLEAR.
    - last neuron and layer<N_LAYER-1: layer++, neuron=0 → CLEAR.
    - otherwise → DONE.
  - DONE: done=1 for 1 cycle, sample_cnt++ → IDLE.
- Per-neuron cost is fan + MAC_LAT + 3 + W cycles, where W ≥ 1 is the number of WAIT_ACT cycles.
- With defaults and act_ready tied high:
  - layer-0 neurons take 13 cycles; layer 1–2 neurons take 9 cycles.
  - 124 working cycles, and done is high in cycle 125 after the start-accepting edge.
  - Final w_addr = 64, which wraps to 0 in 6 bits.
- Simultaneous start and act_ready are irrelevant: they are never sampled in the same state.
- err stays high until rst or the next accepted start.
- rst mid-inference aborts immediately to IDLE with all outputs 0. No done pulse.

Test Plan:
- Defaults, act_ready=1, single start pulse → busy for 125 cycles. done pulses exactly once at cycle 125. sample_cnt=1. w_addr sequence 0..63 with no gaps or repeats.
- Same run, monitor wr_en → 12 writes: (bank0, addr0..3), then (bank1, addr0..3), then (bank0, addr0..3). in_sel=0 only during layer 0. rd_bank=0 in layer 1 and 1 in layer 2.
- act_ready delayed 5 cycles after each act_start → total cycle count 124 + 12×4 = 172 before done. mac_clr precedes every mac_en burst. mac_last appears once per neuron.
- act_ready held low → after 64 WAIT_ACT cycles, err=1, busy=0, no done, sample_cnt unchanged. A new start clears err and the run completes normally.
- Assert rst during layer 1 MAC → all outputs 0 asynchronously. A subsequent start completes in 125 cycles.
- start pulsed repeatedly while busy, and start held high across DONE → extra pulses while busy are ignored. A start held high in IDLE immediately launches the next inference. sample_cnt increments by 1 per completed inference.
